// File: rtl/rs_pkg.sv
// rs_pkg: shared entry/issue types and default widths for reservation stations
package rs_pkg;
  localparam int RS_PRN_W = 7;
  localparam int RS_ID_W = 6;
  typedef struct packed {
    logic valid;
    logic src_rdy;
    logic [RS_PRN_W-1:0] src_prn;
    logic [63:0] src_val;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [RS_ID_W-1:0] inst_id;
    logic [RS_PRN_W-1:0] out_prn;
    logic out_prn_valid;
  } rs_entry_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] op0;
    logic [RS_ID_W-1:0] inst_id;
    logic [RS_PRN_W-1:0] out_prn;
    logic out_prn_valid;
  } iss_bundle_t;
endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: age matrix with oldest-requester one-hot grant
module rs_age_select #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);
  logic [DEPTH-1:0] older [DEPTH];
  // a newly allocated entry becomes younger than every other entry
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (rst || i == j) older[i][j] <= 1'b0;
        else if (alloc[i]) older[i][j] <= 1'b0;
        else if (alloc[j]) older[i][j] <= 1'b1;
  end
  // grant a requester that no other requester is older than
  always_comb begin
    grant = req;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (j != i && req[j] && older[j][i]) grant[i] = 1'b0;
  end
endmodule

// File: rtl/rs_dpi.sv
// rs_dpi: DPI-unit reservation station; RS_DPI_WAKEUP_BYPASS_EN lets a broadcast entry issue on the same edge
module rs_dpi import rs_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int PRN_W = RS_PRN_W,
  parameter int ID_W = RS_ID_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [63:0]      in_pc,
  input  logic [ID_W-1:0]  in_inst_id,
  input  logic [PRN_W-1:0] in_src_prn,
  input  logic             in_src_rdy,
  input  logic [63:0]      in_src_val,
  input  logic [PRN_W-1:0] in_out_prn,
  input  logic             in_out_prn_valid,
  input  logic             cdb_valid,
  input  logic [PRN_W-1:0] cdb_prn,
  input  logic [63:0]      cdb_data,
  input  logic             fu_ready,
  output logic             iss_valid,
  output logic [31:0]      iss_inst,
  output logic [63:0]      iss_pc,
  output logic [63:0]      iss_op0,
  output logic [ID_W-1:0]  iss_inst_id,
  output logic [PRN_W-1:0] iss_out_prn,
  output logic             iss_out_prn_valid
);
  localparam int CW = $clog2(DEPTH + 1);
  rs_entry_t ent [DEPTH];
  iss_bundle_t iss_q, pick;
  logic [CW-1:0] count;
  logic [DEPTH-1:0] wake, req, grant, free_oh, alloc;
  logic do_alloc, do_iss, in_hit;
  assign in_ready = count < CW'(DEPTH);
  assign do_alloc = in_valid && in_ready && !flush;
  assign in_hit = cdb_valid && in_src_prn == cdb_prn;
  assign do_iss = fu_ready && |grant;
  assign alloc = do_alloc ? free_oh : '0;
  assign {iss_inst, iss_pc, iss_op0, iss_inst_id, iss_out_prn, iss_out_prn_valid} = iss_q;
  rs_age_select #(.DEPTH(DEPTH)) u_sel (.clk(clk), .rst(rst), .alloc(alloc), .req(req), .grant(grant));
  // wakeup matches, ready requests, lowest free slot and the granted bundle
  always_comb begin
    free_oh = '0;
    pick = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      wake[i] = ent[i].valid && !ent[i].src_rdy && cdb_valid && ent[i].src_prn == cdb_prn;
`ifdef RS_DPI_WAKEUP_BYPASS_EN
      req[i] = ent[i].valid && (ent[i].src_rdy || wake[i]);
`else
      req[i] = ent[i].valid && ent[i].src_rdy;
`endif
      if (!ent[i].valid) begin
        free_oh = '0;
        free_oh[i] = 1'b1;
      end
      if (grant[i])
        pick = '{inst: ent[i].inst, pc: ent[i].pc, op0: ent[i].src_rdy ? ent[i].src_val : cdb_data,
                 inst_id: ent[i].inst_id, out_prn: ent[i].out_prn, out_prn_valid: ent[i].out_prn_valid};
    end
  end
  // entry storage, issue register and occupancy; flush outranks everything but reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      iss_q <= '0;
      iss_valid <= 1'b0;
      count <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
      iss_valid <= 1'b0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake[i]) begin
          ent[i].src_rdy <= 1'b1;
          ent[i].src_val <= cdb_data;
        end
        if (do_iss && grant[i]) ent[i].valid <= 1'b0;
        if (alloc[i])
          ent[i] <= '{valid: 1'b1, src_rdy: in_src_rdy || in_hit, src_prn: in_src_prn,
                      src_val: in_src_rdy ? in_src_val : cdb_data, inst: in_inst, pc: in_pc,
                      inst_id: in_inst_id, out_prn: in_out_prn, out_prn_valid: in_out_prn_valid};
      end
      iss_valid <= do_iss;
      if (do_iss) iss_q <= pick;
      count <= count + CW'(do_alloc) - CW'(do_iss);
    end
  end
endmodule

// File: tb/tb_rs_dpi.sv
// tb_rs_dpi: directed self-checking bench for rs_dpi (honours RS_DPI_WAKEUP_BYPASS_EN)
module tb_rs_dpi;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, in_ready, in_src_rdy = 0, in_out_prn_valid = 0;
  logic [31:0] in_inst = 0;
  logic [63:0] in_pc = 0, in_src_val = 0, cdb_data = 0;
  logic [5:0] in_inst_id = 0;
  logic [6:0] in_src_prn = 0, in_out_prn = 0, cdb_prn = 0;
  logic cdb_valid = 0, fu_ready = 0, iss_valid, iss_out_prn_valid;
  logic [31:0] iss_inst;
  logic [63:0] iss_pc, iss_op0;
  logic [5:0] iss_inst_id;
  logic [6:0] iss_out_prn;
  int errors = 0, checks = 0;

  rs_dpi dut (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_inst_id(in_inst_id), .in_src_prn(in_src_prn),
    .in_src_rdy(in_src_rdy), .in_src_val(in_src_val), .in_out_prn(in_out_prn),
    .in_out_prn_valid(in_out_prn_valid), .cdb_valid(cdb_valid), .cdb_prn(cdb_prn),
    .cdb_data(cdb_data), .fu_ready(fu_ready), .iss_valid(iss_valid), .iss_inst(iss_inst),
    .iss_pc(iss_pc), .iss_op0(iss_op0), .iss_inst_id(iss_inst_id), .iss_out_prn(iss_out_prn),
    .iss_out_prn_valid(iss_out_prn_valid));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] id, input logic [6:0] prn, input logic rdy, input logic [63:0] val);
    in_valid = v;
    in_inst_id = id;
    in_src_prn = prn;
    in_src_rdy = rdy;
    in_src_val = val;
    in_inst = 32'hD280_0000 | 32'(id);
    in_pc = 64'h1000 + 64'(id) * 4;
    in_out_prn = {1'b0, id};
    in_out_prn_valid = 1'b1;
  endtask

  task automatic cdb(input logic v, input logic [6:0] prn, input logic [63:0] data);
    cdb_valid = v;
    cdb_prn = prn;
    cdb_data = data;
  endtask

  task automatic test_reset();
    rst = 1;
    step();
    step();
    rst = 0;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid got %0b exp 0", iss_valid); end
    checks++; if (iss_inst_id !== 6'd0) begin errors++; $display("FAIL reset_iss_inst_id got %0d exp 0", iss_inst_id); end
    checks++; if (iss_op0 !== 64'd0) begin errors++; $display("FAIL reset_iss_op0 got %h exp 0", iss_op0); end
    checks++; if (iss_pc !== 64'd0) begin errors++; $display("FAIL reset_iss_pc got %h exp 0", iss_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_movz();
    fu_ready = 1;
    drive(1, 5, 0, 1, 64'h1234);
    step();
    drive(0, 0, 0, 0, 0);
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL movz_not_yet got %0b exp 0", iss_valid); end
    step();
    checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL movz_valid got %0b exp 1", iss_valid); end
    checks++; if (iss_inst_id !== 6'd5) begin errors++; $display("FAIL movz_id got %0d exp 5", iss_inst_id); end
    checks++; if (iss_op0 !== 64'h1234) begin errors++; $display("FAIL movz_op0 got %h exp 1234", iss_op0); end
    checks++; if (iss_pc !== 64'h1014) begin errors++; $display("FAIL movz_pc got %h exp 1014", iss_pc); end
    checks++; if (iss_inst !== 32'hD280_0005) begin errors++; $display("FAIL movz_inst got %h exp d2800005", iss_inst); end
    checks++; if (iss_out_prn !== 7'd5 || iss_out_prn_valid !== 1'b1) begin errors++; $display("FAIL movz_out_prn got %0d/%0b exp 5/1", iss_out_prn, iss_out_prn_valid); end
    step();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL movz_drained got %0b exp 0", iss_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL movz_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_wakeup();
    fu_ready = 1;
    drive(1, 7, 12, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL wake_wait got %0b exp 0", iss_valid); end
    cdb(1, 12, 64'hDEAD_BEEF);
    step();
    cdb(0, 0, 0);
`ifndef RS_DPI_WAKEUP_BYPASS_EN
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL wake_latency got %0b exp 0", iss_valid); end
    step();
`endif
    checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL wake_valid got %0b exp 1", iss_valid); end
    checks++; if (iss_inst_id !== 6'd7) begin errors++; $display("FAIL wake_id got %0d exp 7", iss_inst_id); end
    checks++; if (iss_op0 !== 64'hDEAD_BEEF) begin errors++; $display("FAIL wake_op0 got %h exp deadbeef", iss_op0); end
    step();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL wake_drained got %0b exp 0", iss_valid); end
  endtask

  task automatic test_back_to_back();
    fu_ready = 0;
    for (int k = 1; k <= 3; k++) begin
      drive(1, 6'(k), 0, 1, 64'(100 + k));
      step();
    end
    drive(0, 0, 0, 0, 0);
    step();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL b2b_held got %0b exp 0", iss_valid); end
    fu_ready = 1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'(k)) begin errors++; $display("FAIL b2b_order got %0b/%0d exp 1/%0d", iss_valid, iss_inst_id, k); end
      checks++; if (iss_op0 !== 64'(100 + k)) begin errors++; $display("FAIL b2b_op0 got %0d exp %0d", iss_op0, 100 + k); end
    end
    step();
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b exp 0", iss_valid); end
    fu_ready = 0;
  endtask

  task automatic test_age();
    fu_ready = 0;
    drive(1, 20, 0, 1, 64'd20);
    step();
    drive(1, 21, 30, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    fu_ready = 1;
    step();
    checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd20) begin errors++; $display("FAIL age_first got %0b/%0d exp 1/20", iss_valid, iss_inst_id); end
    fu_ready = 0;
    cdb(1, 30, 64'h3030);
    step();
    cdb(0, 0, 0);
    drive(1, 22, 0, 1, 64'd22);
    step();
    drive(0, 0, 0, 0, 0);
    fu_ready = 1;
    step();
    checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd21) begin errors++; $display("FAIL age_older_high_slot got %0b/%0d exp 1/21", iss_valid, iss_inst_id); end
    checks++; if (iss_op0 !== 64'h3030) begin errors++; $display("FAIL age_op0 got %h exp 3030", iss_op0); end
    step();
    checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd22) begin errors++; $display("FAIL age_younger got %0b/%0d exp 1/22", iss_valid, iss_inst_id); end
    fu_ready = 0;
    step();
  endtask

  task automatic test_full();
    fu_ready = 0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready got %0b exp 1 at %0d", in_ready, k); end
      drive(1, 6'(30 + k), 7'(40 + k), 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0b exp 0", in_ready); end
    cdb(1, 42, 64'h42);
    fu_ready = 1;
    step();
    cdb(0, 0, 0);
`ifndef RS_DPI_WAKEUP_BYPASS_EN
    checks++; if (iss_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL full_wake_only got %0b/%0b exp 0/0", iss_valid, in_ready); end
    step();
`endif
    checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd32) begin errors++; $display("FAIL full_issue got %0b/%0d exp 1/32", iss_valid, iss_inst_id); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_freed got %0b exp 1", in_ready); end
  endtask

  task automatic test_flush();
    flush = 1;
    cdb(1, 43, 64'h43);
    step();
    flush = 0;
    cdb(0, 0, 0);
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL flush_iss_valid got %0b exp 0", iss_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b exp 1", in_ready); end
    for (int k = 0; k < 4; k++) begin
      cdb(1, 7'(40 + k), 64'(k));
      step();
      checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got %0b/%0d exp 0 prn %0d", iss_valid, iss_inst_id, 40 + k); end
    end
    cdb(0, 0, 0);
    step();
    fu_ready = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 6'(50 + k), 7'(60 + k), 0, 0);
      step();
      checks++; if (in_ready !== (k < 3)) begin errors++; $display("FAIL flush_count got %0b exp %0b after %0d", in_ready, k < 3, k + 1); end
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_dispatch_bypass();
    rst = 1;
    step();
    rst = 0;
    fu_ready = 1;
    drive(1, 9, 9, 0, 64'h5555);
    cdb(1, 9, 64'h99);
    step();
    drive(0, 0, 0, 0, 0);
    cdb(0, 0, 0);
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL dbyp_wait got %0b exp 0", iss_valid); end
    step();
    checks++; if (iss_valid !== 1'b1 || iss_inst_id !== 6'd9) begin errors++; $display("FAIL dbyp_issue got %0b/%0d exp 1/9", iss_valid, iss_inst_id); end
    checks++; if (iss_op0 !== 64'h99) begin errors++; $display("FAIL dbyp_op0 got %h exp 99", iss_op0); end
  endtask

  initial begin
    test_reset();
    test_movz();
    test_wakeup();
    test_back_to_back();
    test_age();
    test_full();
    test_flush();
    test_dispatch_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rs_dpi.md
# rs_dpi

Reservation station for the data-processing-immediate functional unit (MOVK/MOVZ/ADR/ADRP). It sits between rename/dispatch and the DPI unit. It buffers up to DEPTH dispatched instructions and captures their single source operand from the result broadcast bus. It issues the oldest operand-ready entry into the unit's `inst`/`op[0]`/`pc`/`inst_id`/`out_prn` inputs whenever the unit reports `fu_ready`.

## Interface
- DEPTH, 4, number of entries (≥2)
- PRN_W, 7, physical register number width
- ID_W, 6, instruction id width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries and any pending issue
- in_valid  in  1  dispatch request
- in_ready  out  1  station can accept this cycle
- in_inst  in  32  instruction word
- in_pc  in  64  instruction pc
- in_inst_id  in  ID_W  ROB id
- in_src_prn  in  PRN_W  source physical register (MOVK destination-old value)
- in_src_rdy  in  1  operand already available (tie 1 for MOVZ/ADR/ADRP)
- in_src_val  in  64  operand value when in_src_rdy
- in_out_prn  in  PRN_W  destination PRN
- in_out_prn_valid  in  1  destination valid
- cdb_valid  in  1  result broadcast valid
- cdb_prn  in  PRN_W  broadcast PRN
- cdb_data  in  64  broadcast value
- fu_ready  in  1  DPI unit accepts an instruction
- iss_valid  out  1  issue bundle valid (drives unit inst_valid)
- iss_inst / iss_pc / iss_op0 / iss_inst_id / iss_out_prn / iss_out_prn_valid  out  32/64/64/ID_W/PRN_W/1  issue bundle

## Operation
- Entry fields: valid, src_rdy, src_prn, src_val, inst, pc, inst_id, out_prn, out_prn_valid.
- Age tracking: a DEPTH×DEPTH age matrix. On allocation, the new entry is marked younger than all currently valid entries.
- Allocation: lowest-index free entry. in_ready = (count < DEPTH), computed from registered state only. A same-cycle issue does not free a slot for the same-cycle dispatch.
- Wakeup: each valid entry with !src_rdy and src_prn == cdb_prn while cdb_valid captures cdb_data and sets src_rdy.
- A dispatch in the same cycle whose in_src_prn matches a broadcast is written as ready with cdb_data, even when in_src_rdy=0.
- Select: among valid && src_rdy entries, pick the oldest per the age matrix.
- Issue: when fu_ready and a selection exists, load the issue registers, clear the entry, and set iss_valid=1. Otherwise set iss_valid=0 and hold the bundle.
- Flush: clears all valid bits and iss_valid next edge. It overrides dispatch, wakeup and issue in the same cycle.
- Count: 0..DEPTH. Dispatch and issue in the same cycle leave count unchanged.

## Timing
- Reset values: iss_valid=0, all iss_* data =0, in_ready=1, all entries invalid, count=0.
- Reset or flush mid-operation discards all contents, with no partial issue.
- Issue registers are updated at the clock edge.
- Dispatch with a ready operand at edge E0 issues at E1: iss_valid is high during the cycle after E1. Minimum dispatch-to-issue is 1 cycle.
- Wakeup at edge E makes an entry selectable in the cycle after E. Earliest issue is E+1.
- The station issues at most one instruction per cycle.
- Full: in_ready=0. A dispatch attempted while full is ignored, and the bench must not drive it.
- Empty, or no ready entry: iss_valid=0 next edge regardless of fu_ready.

## Configuration
- RS_DPI_WAKEUP_BYPASS_EN defined: select also considers entries whose operand matches the current broadcast. Such an entry issues at the same edge E with iss_op0=cdb_data, so wakeup-to-issue is 0 cycles. Dispatch-time matches still wait one cycle.
- RS_DPI_WAKEUP_BYPASS_EN undefined: wakeup-to-issue is 1 cycle, as in Timing.

## Structure
- Shared package `rs_pkg`: `rs_entry_t` struct (fields above), the PRN_W/ID_W defaults, and an `iss_bundle_t` struct reused by other station variants.
- Sub-module `rs_age_select`: the age matrix plus the oldest-ready one-hot picker. It is parameterised on DEPTH and reusable by other stations.

## Test plan
- Dispatch MOVZ (in_src_rdy=1, in_inst_id=5) into an empty station with fu_ready=1 → iss_valid one cycle later with iss_inst_id=5 and count back to 0.
- Dispatch MOVK waiting on PRN 12, then broadcast cdb_prn=12, cdb_data=0xDEAD_BEEF → iss_op0=0xDEAD_BEEF. Issue follows the broadcast by 1 cycle, or by 0 cycles with the bypass macro.
- Dispatch ids 1, 2, 3 (all ready) with fu_ready=0, then raise fu_ready → issue order 1, 2, 3 on consecutive cycles.
- Fill DEPTH=4 entries, all waiting → in_ready=0. Wake one entry and issue it → in_ready=1 only on the cycle after the issue.
- Broadcast PRN 9 in the same cycle as a dispatch with in_src_prn=9 and in_src_rdy=0 → entry is captured ready and issues with cdb_data.
- Assert flush while 3 entries are valid and iss_valid=1 → next cycle iss_valid=0, count=0, in_ready=1, and no later issue of those ids.
